pipeline_hazard_unit: RTL

//  Interlock/flush controller for the 5-stage datapath (no forwarding paths).

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hazard_cmp.sv | 29 ++
 rtl/pipeline_hazard_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage pipeline interlock/flush controller.
package pipeline_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // Which pipeline-control case wins this cycle, highest priority first.
    typedef enum logic [2:0] {
        PC_NONE   = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JR     = 3'd2,
        PC_HAZARD = 3'd3,
        PC_JUMP   = 3'd4
    } prio_e;

endpackage

// File: rtl/hazard_cmp.sv
// RAW check of one ID source register against the in-flight EX/MEM/WB destinations.
module hazard_cmp
    import pipeline_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             uses_i,
    input  logic             ex_we_i,
    input  logic [REG_W-1:0] ex_wr_i,
    input  logic             mem_we_i,
    input  logic [REG_W-1:0] mem_wr_i,
    input  logic             wb_we_i,
    input  logic [REG_W-1:0] wb_wr_i,
    output logic             hit_o
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = ex_we_i  && (ex_wr_i  == src_i);
    assign mem_hit = mem_we_i && (mem_wr_i == src_i);
    // With a write-before-read register file the WB result is already visible.
    assign wb_hit  = (WB_BYPASS == 0) && wb_we_i && (wb_wr_i == src_i);

    assign hit_o = uses_i && (src_i != REG_ZERO) && (ex_hit || mem_hit || wb_hit);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Interlock/flush controller: priority logic, FSM, saturating counters and stall watchdog.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_Jump,
    input  logic             EX_Jr,
    input  logic             MEM_PCSrc,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_WriteReg,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic             StallErr
);

    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [7:0]       WD_LIMIT = 8'(MAX_STALL);
    localparam logic [7:0]       WD_ONE   = 8'd1;

    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;
    prio_e      prio;
    state_e     state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
    logic       stall_inc;
    logic       flush_inc;

    hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs (
        .src_i(ID_Rs), .uses_i(ID_UsesRs),
        .ex_we_i(EX_RegWrite), .ex_wr_i(EX_WriteReg),
        .mem_we_i(MEM_RegWrite), .mem_wr_i(MEM_WriteReg),
        .wb_we_i(WB_RegWrite), .wb_wr_i(WB_WriteReg),
        .hit_o(rs_hit)
    );

    hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rt (
        .src_i(ID_Rt), .uses_i(ID_UsesRt),
        .ex_we_i(EX_RegWrite), .ex_wr_i(EX_WriteReg),
        .mem_we_i(MEM_RegWrite), .mem_wr_i(MEM_WriteReg),
        .wb_we_i(WB_RegWrite), .wb_wr_i(WB_WriteReg),
        .hit_o(rt_hit)
    );

    assign hazard = rs_hit || rt_hit;

    always_comb begin
        prio = PC_NONE;
        if (MEM_PCSrc)    prio = PC_BRANCH;
        else if (EX_Jr)   prio = PC_JR;
        else if (hazard)  prio = PC_HAZARD;
        else if (ID_Jump) prio = PC_JUMP;
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        case (prio)
            PC_BRANCH: begin
                IFID_Flush  = 1'b1;
                IDEX_Flush  = 1'b1;
                EXMEM_Flush = 1'b1;
            end
            PC_JR: begin
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end
            PC_HAZARD: begin
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
            end
            PC_JUMP:  IFID_Flush = 1'b1;
            default: ;
        endcase
        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end
    end

    // Every state shares the same transition rules; the state only records the last cycle's case.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (prio == PC_BRANCH || prio == PC_JR) state_d = ST_FLUSH;
                else if (prio == PC_HAZARD)             state_d = ST_STALL;
                else                                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_inc = (prio == PC_HAZARD);
    assign flush_inc = (prio == PC_BRANCH) || (prio == PC_JR) || (prio == PC_JUMP);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
        wd_d = '0;
        if (stall_inc) wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_ONE;
        err_d = err_q || (wd_d == WD_LIMIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
        end
    end

    assign State    = state_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign StallErr = err_q;

endmodule
